// File: rtl/redmule_pkg.sv
// Shared RedMulE types for the X loader: element formats, loader FSM states,
// the latched loader configuration and array geometry defaults.
package redmule_pkg;

  localparam int unsigned ARRAY_HEIGHT    = 4;
  localparam int unsigned ARRAY_WIDTH     = 12;
  localparam int unsigned X_LOADER_TILE_W = 16;
  // Storage width of the latched rows/cols fields; wide enough for any RW/CW in use.
  localparam int unsigned X_LOADER_RC_W   = 8;

  typedef enum logic [1:0] {
    FP32 = 2'd0,
    FP64 = 2'd1,
    FP16 = 2'd2,
    FP8  = 2'd3
  } fp_format_e;

  typedef enum logic [2:0] {
    XL_IDLE      = 3'd0,
    XL_LOAD      = 3'd1,
    XL_WAIT_FULL = 3'd2,
    XL_WAIT_ACK  = 3'd3,
    XL_DONE      = 3'd4
  } x_loader_state_e;

  typedef struct packed {
    logic [X_LOADER_RC_W-1:0]   rows;
    logic [X_LOADER_RC_W-1:0]   cols;
    logic [X_LOADER_TILE_W-1:0] tiles;
  } x_loader_cfg_t;

  function automatic int unsigned fp_width(input fp_format_e fmt);
    case (fmt)
      FP32:    return 32;
      FP64:    return 64;
      FP16:    return 16;
      FP8:     return 8;
      default: return 16;
    endcase
  endfunction

endpackage

// File: rtl/redmule_x_lane_mask.sv
// Combinational lane mask: element lanes at or above cols are forced to zero so
// partial rows never leak stale streamer data into the X buffer.
module redmule_x_lane_mask #(
  parameter int unsigned DW   = 288,
  parameter int unsigned BITW = 16,
  parameter int unsigned CW   = 8
) (
  input  logic [DW-1:0] data,
  input  logic [CW-1:0] cols,
  output logic [DW-1:0] masked
);

  localparam int unsigned NEL = DW / BITW;

  // Pass lane e only when it lies below the valid element count.
  always_comb begin
    masked = '0;
    for (int e = 0; e < NEL; e++) begin
      if (int'(cols) > e) begin
        masked[e*BITW +: BITW] = data[e*BITW +: BITW];
      end else begin
        masked[e*BITW +: BITW] = '0;
      end
    end
  end

endmodule

// File: rtl/redmule_x_loader.sv
// X loader: accepts streamer rows, writes them masked into the X buffer one
// registered load per row, and sequences full / ack / write-index reset per tile.
// Optional starvation counter enabled by defining REDMULE_X_LOADER_PERF_EN.
module redmule_x_loader import redmule_pkg::*; #(
  parameter int unsigned DW       = 288,
  parameter fp_format_e  FpFormat = FP16,
  parameter int unsigned Height   = ARRAY_HEIGHT,
  parameter int unsigned Width    = ARRAY_WIDTH,
  localparam int unsigned BITW    = fp_width(FpFormat),
  localparam int unsigned NEL     = DW / BITW,
  localparam int unsigned RW      = $clog2(Width) + 1,
  localparam int unsigned CW      = $clog2(NEL) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          start_i,
  input  logic [RW-1:0] rows_i,
  input  logic [CW-1:0] cols_i,
  input  logic [15:0]   tiles_i,
  input  logic          x_valid_i,
  output logic          x_ready_o,
  input  logic [DW-1:0] x_data_i,
  output logic          load_o,
  output logic [DW-1:0] data_o,
  output logic          rst_w_index_o,
  input  logic          full_i,
  output logic          tile_ready_o,
  input  logic          tile_ack_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [31:0]   stall_cnt_o
);

  if (Height < 1 || Width < 1 || NEL < 1 || RW > X_LOADER_RC_W || CW > X_LOADER_RC_W) begin : gen_param_err
    $error("redmule_x_loader: unsupported geometry");
  end

  x_loader_state_e             state_q, state_d;
  x_loader_cfg_t               cfg_q;
  logic [RW-1:0]               row_cnt_q;
  logic [X_LOADER_TILE_W-1:0]  tile_cnt_q;
  logic                        ready_q, load_q, rst_w_q, tile_ready_q, busy_q, done_q;
  logic [DW-1:0]               data_q, masked_s;
  logic                        hs_s, row_last_s, tile_last_s, start_ok_s, ack_ok_s;

  assign hs_s        = x_valid_i & ready_q;
  assign row_last_s  = (X_LOADER_RC_W'(row_cnt_q) == (cfg_q.rows - X_LOADER_RC_W'(1)));
  assign tile_last_s = (tile_cnt_q == (cfg_q.tiles - 16'd1));
  assign start_ok_s  = start_i & (state_q == XL_IDLE);
  assign ack_ok_s    = tile_ack_i & (state_q == XL_WAIT_ACK);

  redmule_x_lane_mask #(
    .DW   (DW),
    .BITW (BITW),
    .CW   (X_LOADER_RC_W)
  ) i_lane_mask (
    .data   (x_data_i),
    .cols   (cfg_q.cols),
    .masked (masked_s)
  );

  // Next-state logic; clear forces IDLE over any other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      XL_IDLE: begin
        if (start_i) begin
          state_d = (tiles_i == 16'd0) ? XL_DONE : XL_LOAD;
        end else begin
          state_d = XL_IDLE;
        end
      end
      XL_LOAD: begin
        if (hs_s && row_last_s) begin
          state_d = XL_WAIT_FULL;
        end else begin
          state_d = XL_LOAD;
        end
      end
      XL_WAIT_FULL: begin
        if (full_i) begin
          state_d = XL_WAIT_ACK;
        end else begin
          state_d = XL_WAIT_FULL;
        end
      end
      XL_WAIT_ACK: begin
        if (tile_ack_i) begin
          state_d = tile_last_s ? XL_DONE : XL_LOAD;
        end else begin
          state_d = XL_WAIT_ACK;
        end
      end
      XL_DONE: state_d = XL_IDLE;
      default: state_d = XL_IDLE;
    endcase
    if (clear_i) begin
      state_d = XL_IDLE;
    end else begin
      state_d = state_d;
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= XL_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered outputs, counters and latched configuration.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_q        <= '0;
      row_cnt_q    <= '0;
      tile_cnt_q   <= '0;
      ready_q      <= 1'b0;
      load_q       <= 1'b0;
      data_q       <= '0;
      rst_w_q      <= 1'b0;
      tile_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else if (clear_i) begin
      cfg_q        <= '0;
      row_cnt_q    <= '0;
      tile_cnt_q   <= '0;
      ready_q      <= 1'b0;
      load_q       <= 1'b0;
      data_q       <= '0;
      rst_w_q      <= 1'b0;
      tile_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      if (start_ok_s) begin
        cfg_q.rows  <= X_LOADER_RC_W'(rows_i);
        cfg_q.cols  <= X_LOADER_RC_W'(cols_i);
        cfg_q.tiles <= tiles_i;
      end else begin
        cfg_q <= cfg_q;
      end
      if (start_ok_s) begin
        row_cnt_q <= '0;
      end else if (hs_s) begin
        row_cnt_q <= row_last_s ? '0 : row_cnt_q + RW'(1);
      end else begin
        row_cnt_q <= row_cnt_q;
      end
      if (start_ok_s) begin
        tile_cnt_q <= '0;
      end else if (ack_ok_s) begin
        tile_cnt_q <= tile_cnt_q + 16'd1;
      end else begin
        tile_cnt_q <= tile_cnt_q;
      end
      if (hs_s) begin
        data_q <= masked_s;
      end else begin
        data_q <= data_q;
      end
      load_q       <= hs_s;
      rst_w_q      <= ack_ok_s;
      ready_q      <= (state_d == XL_LOAD);
      tile_ready_q <= (state_d == XL_WAIT_ACK);
      busy_q       <= (state_d != XL_IDLE);
      done_q       <= (state_q == XL_DONE);
    end
  end

`ifdef REDMULE_X_LOADER_PERF_EN
  logic [31:0] stall_q;

  // Saturating count of LOAD cycles starved of streamer data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= 32'd0;
    end else if (clear_i || start_ok_s) begin
      stall_q <= 32'd0;
    end else if ((state_q == XL_LOAD) && !x_valid_i && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end else begin
      stall_q <= stall_q;
    end
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = 32'd0;
`endif

  assign x_ready_o     = ready_q;
  assign load_o        = load_q;
  assign data_o        = data_q;
  assign rst_w_index_o = rst_w_q;
  assign tile_ready_o  = tile_ready_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_redmule_x_loader.sv
// Directed bench for redmule_x_loader (W=12, H=4, FP16, DW=288, NEL=18).
module tb_redmule_x_loader;

  logic         clk = 1'b0;
  logic         rst_n, clear, start, x_valid, x_ready, load, rst_w, full, tile_ready, ack, busy, done;
  logic [4:0]   rows;
  logic [5:0]   cols;
  logic [15:0]  tiles;
  logic [287:0] x_data, data;
  logic [31:0]  stall;

  int errors = 0;
  int checks = 0;
  int n_load = 0, n_rstw = 0, n_done = 0, n_overlap = 0;
  int l0, r0, d0;
  logic [287:0] exp_part;

  redmule_x_loader dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .start_i(start),
    .rows_i(rows), .cols_i(cols), .tiles_i(tiles),
    .x_valid_i(x_valid), .x_ready_o(x_ready), .x_data_i(x_data),
    .load_o(load), .data_o(data), .rst_w_index_o(rst_w),
    .full_i(full), .tile_ready_o(tile_ready), .tile_ack_i(ack),
    .busy_o(busy), .done_o(done), .stall_cnt_o(stall)
  );

  always #5 clk = ~clk;

  // Pulse counters and overlap watch, sampled on the inactive edge.
  always @(negedge clk) begin
    if (load) n_load++;
    if (rst_w) n_rstw++;
    if (done) n_done++;
    if ((load && rst_w) || (tile_ready && x_ready)) n_overlap++;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, x_ready, 1'b0);
    chk({tag, "_load"}, load, 1'b0);
    chk({tag, "_data"}, data, 288'd0);
    chk({tag, "_rstw"}, rst_w, 1'b0);
    chk({tag, "_tready"}, tile_ready, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_stall"}, stall, 32'd0);
  endtask

  function automatic logic [287:0] pat(input int i);
    logic [15:0] w;
    w = 16'hA000 + 16'(i);
    return {18{w}};
  endfunction

  // One full 12-row tile with an always-valid streamer, then full, ack, done.
  task automatic run_full_tile(input string tag);
    l0 = n_load;
    rows = 5'd12; cols = 6'd18; tiles = 16'd1; x_valid = 1'b1; x_data = pat(0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_ready_on"}, x_ready, 1'b1);
    chk({tag, "_noload0"}, load, 1'b0);
    for (int i = 0; i < 12; i++) begin
      x_data = pat(i);
      tick();
      chk({tag, "_load"}, load, 1'b1);
      chk({tag, "_data"}, data, pat(i));
      chk({tag, "_ready"}, x_ready, (i == 11) ? 1'b0 : 1'b1);
    end
    x_valid = 1'b0; full = 1'b1;
    tick();
    full = 1'b0;
    chk({tag, "_tready"}, tile_ready, 1'b1);
    chk({tag, "_noload"}, load, 1'b0);
    tick();
    chk({tag, "_tready_hold"}, tile_ready, 1'b1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk({tag, "_rstw"}, rst_w, 1'b1);
    chk({tag, "_tready_off"}, tile_ready, 1'b0);
    chk({tag, "_done_early"}, done, 1'b0);
    tick();
    chk({tag, "_rstw_off"}, rst_w, 1'b0);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_busy_off"}, busy, 1'b0);
    tick();
    chk({tag, "_done_off"}, done, 1'b0);
    chk({tag, "_nload"}, 288'(n_load - l0), 288'd12);
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; start = 1'b0; rows = '0; cols = '0; tiles = '0;
    x_valid = 1'b0; x_data = '0; full = 1'b0; ack = 1'b0;
    exp_part = {{208{1'b0}}, {80{1'b1}}};
    tick(); tick();
    chk_zero("reset");
    rst_n = 1'b1;
    tick();

    // Single full tile.
    run_full_tile("single");

    // Partial lanes, full_i held high during LOAD must be ignored.
    rows = 5'd2; cols = 6'd5; tiles = 16'd1; x_valid = 1'b1; x_data = '1; full = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("part_load0", load, 1'b1);
    chk("part_data0", data, exp_part);
    chk("part_full_in_load", tile_ready, 1'b0);
    tick();
    x_valid = 1'b0;
    chk("part_load1", load, 1'b1);
    chk("part_data1", data, exp_part);
    tick();
    full = 1'b0;
    chk("part_tready", tile_ready, 1'b1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick(); tick();

    // Three tiles of three rows with two-cycle valid gaps.
    l0 = n_load; r0 = n_rstw; d0 = n_done;
    rows = 5'd3; cols = 6'd18; tiles = 16'd3; x_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 3; t++) begin
      for (int b = 0; b < 3; b++) begin
        x_valid = 1'b0;
        tick(); tick();
        x_valid = 1'b1; x_data = pat(t * 3 + b);
        tick();
        x_valid = 1'b0;
      end
      chk("gap_ready_wf", x_ready, 1'b0);
      full = 1'b1;
      tick();
      full = 1'b0;
      chk("gap_ready_wa", x_ready, 1'b0);
      chk("gap_tready", tile_ready, 1'b1);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("gap_rstw", rst_w, 1'b1);
    end
    tick();
    chk("gap_done", done, 1'b1);
    tick();
    chk("gap_nload", 288'(n_load - l0), 288'd9);
    chk("gap_nrstw", 288'(n_rstw - r0), 288'd3);
    chk("gap_ndone", 288'(n_done - d0), 288'd1);
`ifdef REDMULE_X_LOADER_PERF_EN
    chk("gap_stall", stall, 32'd18);
`else
    chk("gap_stall", stall, 32'd0);
`endif

    // Ack misuse and start while busy: two tiles must both be loaded.
    rows = 5'd2; cols = 6'd18; tiles = 16'd2; x_valid = 1'b0;
    start = 1'b1;
    tick();
    tiles = 16'd0; ack = 1'b1;
    tick();
    start = 1'b0; ack = 1'b0;
    chk("mis_busy", busy, 1'b1);
    chk("mis_ready", x_ready, 1'b1);
    chk("mis_rstw_load", rst_w, 1'b0);
    x_valid = 1'b1;
    tick(); tick();
    x_valid = 1'b0; ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("mis_rstw_wf", rst_w, 1'b0);
    chk("mis_tready_wf", tile_ready, 1'b0);
    full = 1'b1;
    tick();
    full = 1'b0; ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("mis_rstw1", rst_w, 1'b1);
    chk("mis_second_tile", x_ready, 1'b1);
    chk("mis_no_done", done, 1'b0);
    x_valid = 1'b1;
    tick(); tick();
    x_valid = 1'b0; full = 1'b1;
    tick();
    full = 1'b0; ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("mis_rstw2", rst_w, 1'b1);
    tick();
    chk("mis_done", done, 1'b1);
    tick();

    // tiles == 0: straight to done without loads.
    l0 = n_load;
    tiles = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_busy", busy, 1'b1);
    tick();
    chk("zero_done", done, 1'b1);
    tick();
    chk("zero_done_off", done, 1'b0);
    chk("zero_nload", 288'(n_load - l0), 288'd0);

    // Abort after 7 of 12 beats, clear together with start.
    rows = 5'd12; cols = 6'd18; tiles = 16'd1; x_valid = 1'b1; x_data = pat(50);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("abort_load7", load, 1'b1);
    clear = 1'b1; start = 1'b1;
    tick();
    chk_zero("abort");
    clear = 1'b0; start = 1'b0; x_valid = 1'b0;
    tick();
    chk("abort_idle", busy, 1'b0);
    run_full_tile("fresh");

    // Reset in WAIT_ACK with rows == 1.
    rows = 5'd1; cols = 6'd18; tiles = 16'd1; x_valid = 1'b1; x_data = pat(77);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("r1_load", load, 1'b1);
    chk("r1_ready", x_ready, 1'b0);
    x_valid = 1'b0; full = 1'b1;
    tick();
    full = 1'b0;
    chk("r1_tready", tile_ready, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    start = 1'b1;
    tick();
    chk("rst_start_ign", busy, 1'b0);
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("rst_idle", busy, 1'b0);
    chk("no_overlap", 288'(n_overlap), 288'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
